// File: rtl/onewire_sensor_pkg.sv
// onewire_sensor_pkg: shared state encoding, SFR layout and timing helper for the single-wire sensor master
package onewire_sensor_pkg;
  typedef enum logic [2:0] {IDLE, START, RESP, BITS, DONE, ERR} state_t;
  localparam logic [7:0] OFF_CTRL = 8'd0;
  localparam logic [7:0] OFF_DATA0 = 8'd1;
  localparam logic [7:0] OFF_DATA4 = 8'd5;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_TO = 2;
  localparam int ST_CHK = 3;
  function automatic int us_to_cyc(input longint clk_hz, input longint us);
    return int'(clk_hz * us / 64'd1_000_000);
  endfunction
endpackage

// File: rtl/onewire_edge_sync.sv
// onewire_edge_sync: 2-FF synchronizer with a registered falling-edge pulse
module onewire_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic fall
);
  logic [2:0] s;
  // stages start high so an idle (pulled-up) line never yields a false edge after reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s <= '1;
      fall <= 1'b0;
    end else begin
      s <= {s[1:0], d};
      fall <= s[2] & ~s[1];
    end
endmodule

// File: rtl/onewire_sensor_master.sv
// onewire_sensor_master: multi-channel single-wire humidity/temperature reader on the SFR bus
// Define ONEWIRE_CHKSUM_EN to verify the frame checksum into status bit3.
module onewire_sensor_master
  import onewire_sensor_pkg::*;
#(
  parameter int CLK_HZ = 36_927_000,
  parameter int NUM_CH = 2,
  parameter logic [7:0] SFR_BASE = 8'hE1,
  parameter int START_US = 1000,
  parameter int BIT_THR_US = 100,
  parameter int TIMEOUT_US = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic sfr_rd,
  input  logic sfr_wr,
  input  logic [7:0] sfr_addr,
  input  logic [7:0] sfr_data_out,
  output logic [7:0] sfr_data_in,
  inout  wire  [NUM_CH-1:0] sda
);
  localparam int START_CYC = us_to_cyc(CLK_HZ, START_US);
  localparam int THR_CYC = us_to_cyc(CLK_HZ, BIT_THR_US);
  localparam int TO_CYC = us_to_cyc(CLK_HZ, TIMEOUT_US);
  localparam int MAX_A = START_CYC > TO_CYC ? START_CYC : TO_CYC;
  localparam int MAX_CYC = MAX_A > THR_CYC ? MAX_A : THR_CYC;
  localparam int CW = $clog2(MAX_CYC) + 1;
  localparam logic [3:0] NCH = 4'(NUM_CH);
  state_t state;
  logic [2:0] ch;
  logic [CW-1:0] cnt;
  logic [39:0] sh;
  logic [5:0] nb;
  logic resp2, drive, done_f, to_f, chk_f, line, fall, start_ok, chk_bad;
  logic [0:4][7:0] data;
  logic [7:0] off, status;
  logic [2:0] idx;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_pin
    assign sda[i] = (drive && ch == 3'(i)) ? 1'b0 : 1'bz;
  end
  always_comb begin
    line = 1'b1;
    for (int i = 0; i < NUM_CH; i++) if (ch == 3'(i)) line = sda[i];
  end
  onewire_edge_sync u_sync (.clk(clk), .rst(rst), .d(line), .fall(fall));
`ifdef ONEWIRE_CHKSUM_EN
  assign chk_bad = (sh[39:32] + sh[31:24] + sh[23:16] + sh[15:8]) != sh[7:0];
`else
  assign chk_bad = 1'b0;
`endif
  assign start_ok = sfr_wr && sfr_addr == SFR_BASE && sfr_data_out[0] && state == IDLE
                    && {1'b0, sfr_data_out[3:1]} < NCH;
  always_comb begin
    status = {1'b0, ch, 4'b0000};
    status[ST_BUSY] = state != IDLE;
    status[ST_DONE] = done_f;
    status[ST_TO] = to_f;
    status[ST_CHK] = chk_f;
  end
  assign off = sfr_addr - SFR_BASE;
  assign idx = 3'(off - OFF_DATA0);
  assign sfr_data_in = !sfr_rd ? 8'h00 : off == OFF_CTRL ? status :
                       (off >= OFF_DATA0 && off <= OFF_DATA4) ? data[idx] : 8'h00;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      cnt <= '0;
      sh <= '0;
      nb <= '0;
      resp2 <= 1'b0;
      drive <= 1'b0;
      done_f <= 1'b0;
      to_f <= 1'b0;
      chk_f <= 1'b0;
      data <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: if (start_ok) begin
          state <= START;
          ch <= sfr_data_out[3:1];
          cnt <= '0;
          sh <= '0;
          nb <= '0;
          resp2 <= 1'b0;
          drive <= 1'b1;
          done_f <= 1'b0;
          to_f <= 1'b0;
          chk_f <= 1'b0;
        end
        START: if (cnt == CW'(START_CYC - 1)) begin
          drive <= 1'b0;
          cnt <= '0;
          state <= RESP;
        end
        RESP: if (cnt == CW'(TO_CYC)) begin
          state <= ERR;
          done_f <= 1'b1;
          to_f <= 1'b1;
        end else if (fall) begin
          cnt <= '0;
          resp2 <= 1'b1;
          if (resp2) state <= BITS;
        end
        // cnt holds period-1 at the edge since it restarts at zero on each edge
        BITS: if (cnt == CW'(TO_CYC)) begin
          state <= ERR;
          done_f <= 1'b1;
          to_f <= 1'b1;
        end else if (fall) begin
          cnt <= '0;
          sh <= {sh[38:0], cnt >= CW'(THR_CYC - 1)};
          nb <= nb + 1'b1;
          if (nb == 6'd39) state <= DONE;
        end
        DONE: begin
          data <= sh;
          done_f <= 1'b1;
          chk_f <= chk_bad;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
